// File: rtl/fp_mult_avm_driver.sv
// Avalon-MM master that runs one multiply on the fp_mult slave per command:
// write A, B and start, poll busy, then read the result and status into a response.
//
// state   | meaning
// IDLE    | waiting for a command, cmd_ready high
// WR_A    | writing operand A to word 0
// WR_B    | writing operand B to word 1
// WR_GO   | writing 1 to the start register, word 2
// POLL    | reading busy from word 2 (slave stalls while multiplying)
// POLL_WT | waiting for poll read data
// RD_RES  | reading the product from word 3
// RES_WT  | waiting for product read data
// RD_ST   | reading status flags from word 4
// ST_WT   | waiting for status read data
// RESP    | presenting the response until rsp_ready
module fp_mult_avm_driver #(
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic        rsp_timeout,
  output logic [2:0]  avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest
);

  localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD   = LAT_W'(READ_LATENCY - 1);
  localparam logic [TO_W-1:0]  STALL_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_A,
    S_WR_B,
    S_WR_GO,
    S_POLL,
    S_POLL_WT,
    S_RD_RES,
    S_RES_WT,
    S_RD_ST,
    S_ST_WT,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  state_t            req_next;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [TO_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_result_q, rsp_result_d;
  logic [3:0]        rsp_flags_q, rsp_flags_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic [2:0]        avm_address_q, avm_address_d;
  logic              avm_read_q, avm_read_d;
  logic              avm_write_q, avm_write_d;
  logic [31:0]       avm_writedata_q, avm_writedata_d;
  logic              in_req;

  always_comb begin
    state_d         = state_q;
    req_next        = state_q;
    a_d             = a_q;
    b_d             = b_q;
    stall_cnt_d     = stall_cnt_q;
    lat_cnt_d       = lat_cnt_q;
    rsp_result_d    = rsp_result_q;
    rsp_flags_d     = rsp_flags_q;
    rsp_timeout_d   = rsp_timeout_q;
    avm_address_d   = avm_address_q;
    avm_writedata_d = avm_writedata_q;
    in_req          = avm_read_q | avm_write_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          a_d           = cmd_a;
          b_d           = cmd_b;
          rsp_result_d  = '0;
          rsp_flags_d   = '0;
          rsp_timeout_d = 1'b0;
          state_d       = S_WR_A;
        end
      end
      S_WR_A:   req_next = S_WR_B;
      S_WR_B:   req_next = S_WR_GO;
      S_WR_GO:  req_next = S_POLL;
      S_POLL:   req_next = S_POLL_WT;
      S_RD_RES: req_next = S_RES_WT;
      S_RD_ST:  req_next = S_ST_WT;
      S_POLL_WT: begin
        if (lat_cnt_q == '0) state_d = avm_readdata[0] ? S_POLL : S_RD_RES;
        else                 lat_cnt_d = lat_cnt_q - LAT_W'(1);
      end
      S_RES_WT: begin
        if (lat_cnt_q == '0) begin
          rsp_result_d = avm_readdata;
          state_d      = S_RD_ST;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
      end
      S_ST_WT: begin
        if (lat_cnt_q == '0) begin
          rsp_flags_d = avm_readdata[3:0];
          state_d     = S_RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Request states share the advance/stall/abort rule; the abort drops the request mid-stall.
    if (in_req) begin
      if (!avm_waitrequest) begin
        state_d = req_next;
      end else if (stall_cnt_q == STALL_LAST) begin
        state_d       = S_RESP;
        rsp_timeout_d = 1'b1;
        rsp_result_d  = '0;
        rsp_flags_d   = '0;
      end
    end

    if (state_d != state_q) begin
      stall_cnt_d = '0;
      lat_cnt_d   = LAT_LOAD;
    end else if (in_req && avm_waitrequest) begin
      stall_cnt_d = stall_cnt_q + TO_W'(1);
    end

    // Bus and handshake outputs are decoded from the next state so they register with it.
    avm_read_d  = (state_d == S_POLL) || (state_d == S_RD_RES) || (state_d == S_RD_ST);
    avm_write_d = (state_d == S_WR_A) || (state_d == S_WR_B) || (state_d == S_WR_GO);
    cmd_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);

    case (state_d)
      S_WR_A: begin
        avm_address_d   = 3'd0;
        avm_writedata_d = a_d;
      end
      S_WR_B: begin
        avm_address_d   = 3'd1;
        avm_writedata_d = b_d;
      end
      S_WR_GO: begin
        avm_address_d   = 3'd2;
        avm_writedata_d = 32'h1;
      end
      S_POLL:   avm_address_d = 3'd2;
      S_RD_RES: avm_address_d = 3'd3;
      S_RD_ST:  avm_address_d = 3'd4;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      a_q             <= '0;
      b_q             <= '0;
      stall_cnt_q     <= '0;
      lat_cnt_q       <= '0;
      cmd_ready_q     <= 1'b1;
      rsp_valid_q     <= 1'b0;
      rsp_result_q    <= '0;
      rsp_flags_q     <= '0;
      rsp_timeout_q   <= 1'b0;
      avm_address_q   <= '0;
      avm_read_q      <= 1'b0;
      avm_write_q     <= 1'b0;
      avm_writedata_q <= '0;
    end else begin
      state_q         <= state_d;
      a_q             <= a_d;
      b_q             <= b_d;
      stall_cnt_q     <= stall_cnt_d;
      lat_cnt_q       <= lat_cnt_d;
      cmd_ready_q     <= cmd_ready_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_result_q    <= rsp_result_d;
      rsp_flags_q     <= rsp_flags_d;
      rsp_timeout_q   <= rsp_timeout_d;
      avm_address_q   <= avm_address_d;
      avm_read_q      <= avm_read_d;
      avm_write_q     <= avm_write_d;
      avm_writedata_q <= avm_writedata_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_result    = rsp_result_q;
  assign rsp_flags     = rsp_flags_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign avm_address   = avm_address_q;
  assign avm_read      = avm_read_q;
  assign avm_write     = avm_write_q;
  assign avm_writedata = avm_writedata_q;

endmodule

// File: tb/tb_fp_mult_avm_driver.sv
// Bench for fp_mult_avm_driver: behavioural fp_mult slave, bus monitor and
// directed plus random transactions checked against a reference product model.
module tb_fp_mult_avm_driver;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_a, cmd_b;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        rsp_timeout;
  logic [2:0]  avm_address;
  logic        avm_read, avm_write;
  logic [31:0] avm_writedata, avm_readdata;
  logic        avm_waitrequest;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fp_mult_avm_driver #(.READ_LATENCY(1), .TIMEOUT_CYCLES(TO), .TO_W(5)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_timeout(rsp_timeout),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest)
  );

  // Reference single-precision product (truncating) and status flags {ovf,unf,zero,nan}.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    int          e;
    logic        s;
    s = a[31] ^ b[31];
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) return {s, 8'(e + 1), p[46:24]};
    return {s, 8'(e), p[45:23]};
  endfunction

  function automatic logic [3:0] fp_flags(input logic [31:0] a, input logic [31:0] b);
    return (a[30:0] == 31'd0 || b[30:0] == 31'd0) ? 4'b0010 : 4'b0000;
  endfunction

  // Slave model
  int          poll_mode      = 0;
  int          poll_stall_cfg = 0;
  bit          rand_en        = 1'b0;
  logic        rnd_stall      = 1'b0;
  int          busy_cnt       = 0;
  logic [31:0] s_a = '0, s_b = '0, s_res = '0;
  logic [3:0]  s_flags = '0;
  logic [31:0] rdata = 32'hDEADBEEF;
  logic [34:0] wlog[$];
  int          n_reads    = 0;
  int          n_rd_stall = 0;

  assign avm_readdata    = rdata;
  assign avm_waitrequest = rnd_stall |
                           (avm_read && avm_address == 3'd2 && poll_mode == 0 && busy_cnt != 0);

  always @(posedge clk) begin
    rdata     <= 32'hDEADBEEF;
    rnd_stall <= rand_en && ($urandom_range(0, 3) == 0);
    if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    if (avm_write && !avm_waitrequest) begin
      wlog.push_back({avm_address, avm_writedata});
      case (avm_address)
        3'd0: s_a <= avm_writedata;
        3'd1: s_b <= avm_writedata;
        3'd2: if (avm_writedata[0]) begin
          busy_cnt <= poll_stall_cfg;
          s_res    <= fp_mul(s_a, s_b);
          s_flags  <= fp_flags(s_a, s_b);
        end
        default: ;
      endcase
    end
    if (avm_read && !avm_waitrequest) begin
      n_reads <= n_reads + 1;
      case (avm_address)
        3'd2:    rdata <= {31'd0, busy_cnt != 0};
        3'd3:    rdata <= s_res;
        3'd4:    rdata <= {28'd0, s_flags};
        default: rdata <= 32'hBADBAD00;
      endcase
    end
    if (avm_read && avm_waitrequest) n_rd_stall <= n_rd_stall + 1;
  end

  // Bus protocol monitor: one-hot request, signals held while stalled (timeout abort excepted).
  logic        p_stall = 1'b0;
  logic [36:0] p_sig   = '0;
  int          prot_err = 0;

  always @(posedge clk) begin
    if (reset) begin
      p_stall <= 1'b0;
    end else begin
      if (avm_read && avm_write) prot_err <= prot_err + 1;
      else if (p_stall && {avm_read, avm_write, avm_address, avm_writedata} != p_sig &&
               !(!avm_read && !avm_write && rsp_valid && rsp_timeout))
        prot_err <= prot_err + 1;
      p_stall <= (avm_read || avm_write) && avm_waitrequest;
      p_sig   <= {avm_read, avm_write, avm_address, avm_writedata};
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input int mode, input int nstall, input bit rnd, input int hold,
                         input bit exp_to);
    int          lat, w0, r0, s0, polls, exp_lat, exp_rd;
    logic [31:0] er;
    logic [3:0]  ef;
    bit          stable;
    er      = exp_to ? 32'h0 : fp_mul(a, b);
    ef      = exp_to ? 4'h0 : fp_flags(a, b);
    polls   = (mode == 1) ? (nstall + 1) / 2 : 0;
    exp_lat = exp_to ? 4 + TO : ((mode == 1) ? 10 + 2 * polls : 10 + nstall);
    exp_rd  = exp_to ? 0 : 3 + polls;
    poll_mode = mode; poll_stall_cfg = nstall; rand_en = rnd;

    @(negedge clk);
    cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    lat = 0;
    while (!cmd_ready && lat < 50) begin @(negedge clk); lat++; end
    check({tag, "/cmd_ready"}, cmd_ready, 1);
    w0 = wlog.size(); r0 = n_reads; s0 = n_rd_stall;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 500) begin @(negedge clk); lat++; end
    check({tag, "/rsp_valid"}, rsp_valid, 1);
    if (!rnd) check({tag, "/latency"}, lat, exp_lat);
    check({tag, "/result"}, rsp_result, er);
    check({tag, "/flags"}, rsp_flags, ef);
    check({tag, "/timeout"}, rsp_timeout, exp_to);
    check({tag, "/n_writes"}, wlog.size() - w0, 3);
    check({tag, "/wr0"}, wlog[w0], {3'd0, a});
    check({tag, "/wr1"}, wlog[w0+1], {3'd1, b});
    check({tag, "/wr2"}, wlog[w0+2], {3'd2, 32'h1});
    if (mode == 0 || !rnd) check({tag, "/n_reads"}, n_reads - r0, exp_rd);
    if (exp_to) begin
      check({tag, "/stall_cycles"}, n_rd_stall - s0, TO);
      check({tag, "/read_dropped"}, avm_read, 0);
    end
    check({tag, "/protocol"}, prot_err, 0);

    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1; cmd_a = ~a; cmd_b = ~b;
      @(negedge clk);
      if (!rsp_valid || rsp_result !== er || rsp_flags !== ef || cmd_ready) stable = 1'b0;
    end
    if (hold > 0) begin
      check({tag, "/hold_stable"}, stable, 1);
      check({tag, "/hold_no_accept"}, wlog.size() - w0, 3);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "/rsp_dropped"}, rsp_valid, 0);
    check({tag, "/idle_ready"}, cmd_ready, 1);
    check({tag, "/result_held"}, rsp_result, er);
    check({tag, "/timeout_held"}, rsp_timeout, exp_to);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    int          n;
    reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; cmd_a = '0; cmd_b = '0;
    repeat (3) @(negedge clk);
    check("reset/cmd_ready", cmd_ready, 1);
    check("reset/rsp_valid", rsp_valid, 0);
    check("reset/avm_read", avm_read, 0);
    check("reset/avm_write", avm_write, 0);
    check("reset/avm_address", avm_address, 0);
    check("reset/avm_writedata", avm_writedata, 0);
    check("reset/rsp_result", rsp_result, 0);
    check("reset/rsp_flags", rsp_flags, 0);
    check("reset/rsp_timeout", rsp_timeout, 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset/cmd_ready", cmd_ready, 1);

    run_txn("t1_2x3_stall12", 32'h40000000, 32'h40400000, 0, 12, 1'b0, 0, 1'b0);
    check("t1/const_result", rsp_result, 32'h40C00000);
    run_txn("t2_zero", 32'h00000000, 32'h3F800000, 0, 0, 1'b0, 0, 1'b0);
    check("t2/const_flags", rsp_flags, 4'b0010);
    run_txn("t3_nostall", 32'h3FC00000, 32'hC0200000, 0, 0, 1'b0, 0, 1'b0);
    run_txn("t3_pollloop", 32'h41200000, 32'h3E800000, 1, 5, 1'b0, 0, 1'b0);
    run_txn("t4_hold20", 32'h42C80000, 32'h3DCCCCCD, 0, 3, 1'b0, 20, 1'b0);
    run_txn("t5_timeout", 32'h40000000, 32'h40000000, 0, 1000, 1'b0, 2, 1'b1);

    // Reset while the poll read is stalled
    poll_mode = 0; poll_stall_cfg = 12; rand_en = 1'b0;
    @(negedge clk);
    cmd_a = 32'h40800000; cmd_b = 32'h40800000; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!(avm_read && avm_waitrequest) && n < 50) begin @(negedge clk); n++; end
    check("t6/poll_stall_seen", avm_read && avm_waitrequest, 1);
    reset = 1'b1;
    #1;
    check("t6/read_dropped", avm_read, 0);
    check("t6/cmd_ready", cmd_ready, 1);
    check("t6/rsp_valid", rsp_valid, 0);
    @(negedge clk);
    check("t6/read_low_next", avm_read, 0);
    check("t6/rsp_valid_next", rsp_valid, 0);
    reset = 1'b0;
    @(negedge clk);
    check("t6/no_rsp_after", rsp_valid, 0);
    run_txn("t6_fresh", 32'h40800000, 32'h40800000, 0, 2, 1'b0, 0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      ra = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
      rb = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
      if ($urandom_range(0, 7) == 0) ra = 32'h0;
      if ($urandom_range(0, 7) == 0) rb = 32'h80000000;
      run_txn($sformatf("rnd%0d", i), ra, rb, int'($urandom_range(0, 1)),
              int'($urandom_range(0, 6)), ($urandom_range(0, 1) == 1),
              int'($urandom_range(0, 3)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
